// File: rtl/swc.sv
// swc: instruction-driven 24-bit up/down counter with automatic stop at zero
`ifndef Swc_NOP
`define Swc_NOP 4'h0
`define Swc_LD0 4'h1
`define Swc_LD1 4'h2
`define Swc_LD2 4'h3
`define Swc_COU 4'h4
`define Swc_COD 4'h5
`define Swc_CCU 4'h6
`define Swc_CCD 4'h7
`define Swc_CCS 4'h8
`endif
module swc (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [23:0] counter,
    output logic        ready
);
    typedef enum logic [1:0] {READY, COUNT_UP, COUNT_DOWN, ERROR} state_t;
    state_t state, state_nx;
    logic [23:0] counter_nx, inc, dec;
    assign inc = counter + 24'd1;
    assign dec = counter - 24'd1;
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= READY;
            counter <= 24'h000000;
            ready   <= 1'b1;
        end else begin
            state   <= state_nx;
            counter <= counter_nx;
            ready   <= state_nx != ERROR;
        end
    end
    always_comb begin
        counter_nx = counter;
        state_nx   = state;
        if (state != ERROR && inst_en) begin
            state_nx = READY;
            case (inst[11:8])
                `Swc_NOP, `Swc_CCS: ;
                `Swc_LD0: counter_nx[7:0]   = inst[7:0];
                `Swc_LD1: counter_nx[15:8]  = inst[7:0];
                `Swc_LD2: counter_nx[23:16] = inst[7:0];
                `Swc_COU: counter_nx = inc;
                `Swc_COD: counter_nx = dec;
                `Swc_CCU: begin
                    counter_nx = inc;
                    state_nx   = COUNT_UP;
                end
                `Swc_CCD: begin
                    counter_nx = dec;
                    state_nx   = COUNT_DOWN;
                end
                default: state_nx = ERROR;
            endcase
        end else if (state == COUNT_UP) begin
            counter_nx = inc;
            state_nx   = inc == 24'h0 ? READY : COUNT_UP;
        end else if (state == COUNT_DOWN) begin
            counter_nx = dec;
            state_nx   = dec == 24'h0 ? READY : COUNT_DOWN;
        end
    end
endmodule

// File: tb/tb_swc.sv
// tb_swc: directed scoreboard bench for swc
module tb_swc;
  localparam logic [3:0] NOP = 4'h0, LD0 = 4'h1, LD1 = 4'h2, LD2 = 4'h3, COU = 4'h4,
                         COD = 4'h5, CCU = 4'h6, CCD = 4'h7, CCS = 4'h8;
  typedef struct {
    int          id;
    logic [23:0] c;
    logic        r;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inst = 12'h000;
  logic        inst_en = 1'b0;
  logic [23:0] counter;
  logic        ready;
  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          step = 0;
  swc dut (
    .clock(clock),
    .reset(reset),
    .inst(inst),
    .inst_en(inst_en),
    .counter(counter),
    .ready(ready)
  );
  always #5 clock = ~clock;
  task automatic cyc(input logic r, input logic en, input logic [3:0] op, input logic [7:0] imm,
                     input logic [23:0] ec, input logic er);
    exp_t e;
    reset   = r;
    inst_en = en;
    inst    = {op, imm};
    @(posedge clock);
    #1;
    step++;
    e.id = step;
    e.c  = ec;
    e.r  = er;
    q.push_back(e);
  endtask
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if (counter !== e.c || ready !== e.r) begin
        mismatched++;
        $display("FAIL step%0d: counter=%h ready=%b, expected counter=%h ready=%b",
                 e.id, counter, ready, e.c, e.r);
      end
    end
  end
  initial begin
    #20000;
    mismatched++;
    $display("FAIL timeout: stimulus did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    cyc(1, 1, CCU, 8'h00, 24'h000000, 1);
    compared++;
    if (counter !== 24'h000000 || ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset state: counter=%h ready=%b, expected counter=000000 ready=1",
               counter, ready);
    end
    cyc(0, 1, LD0, 8'hF0, 24'h0000F0, 1);
    cyc(0, 1, LD1, 8'hF1, 24'h00F1F0, 1);
    cyc(0, 1, LD2, 8'hF2, 24'hF2F1F0, 1);
    cyc(0, 1, COU, 8'h00, 24'hF2F1F1, 1);
    cyc(0, 1, COD, 8'h00, 24'hF2F1F0, 1);
    cyc(0, 1, CCU, 8'h00, 24'hF2F1F1, 1);
    for (int i = 2; i <= 5; i++) cyc(0, 0, NOP, 8'h00, 24'hF2F1F0 + 24'(i), 1);
    cyc(0, 1, NOP, 8'h00, 24'hF2F1F5, 1);
    cyc(0, 0, NOP, 8'h00, 24'hF2F1F5, 1);
    cyc(0, 1, CCD, 8'h00, 24'hF2F1F4, 1);
    cyc(0, 0, NOP, 8'h00, 24'hF2F1F3, 1);
    cyc(0, 1, CCS, 8'h00, 24'hF2F1F3, 1);
    cyc(0, 0, NOP, 8'h00, 24'hF2F1F3, 1);
    cyc(0, 1, LD0, 8'hFA, 24'hF2F1FA, 1);
    cyc(0, 1, LD1, 8'hFF, 24'hF2FFFA, 1);
    cyc(0, 1, LD2, 8'hFF, 24'hFFFFFA, 1);
    cyc(0, 1, CCU, 8'h5A, 24'hFFFFFB, 1);
    for (int i = 12; i <= 15; i++) cyc(0, 0, NOP, 8'h00, 24'hFFFFF0 + 24'(i), 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 1, LD0, 8'h06, 24'h000006, 1);
    cyc(0, 1, CCD, 8'h00, 24'h000005, 1);
    for (int i = 4; i >= 0; i--) cyc(0, 0, NOP, 8'h00, 24'(i), 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 1, LD0, 8'h06, 24'h000006, 1);
    cyc(0, 1, CCD, 8'h00, 24'h000005, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000004, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000003, 1);
    cyc(0, 1, NOP, 8'h00, 24'h000003, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000003, 1);
    cyc(0, 1, LD0, 8'h00, 24'h000000, 1);
    cyc(0, 1, COD, 8'h00, 24'hFFFFFF, 1);
    cyc(0, 1, COU, 8'h00, 24'h000000, 1);
    cyc(0, 1, CCD, 8'h00, 24'hFFFFFF, 1);
    cyc(0, 0, NOP, 8'h00, 24'hFFFFFE, 1);
    cyc(0, 1, CCU, 8'h00, 24'hFFFFFF, 1);
    cyc(0, 1, CCU, 8'h00, 24'h000000, 1);
    cyc(0, 1, CCU, 8'h00, 24'h000001, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000002, 1);
    cyc(0, 1, CCS, 8'h00, 24'h000002, 1);
    cyc(0, 1, 4'hF, 8'h00, 24'h000002, 0);
    cyc(0, 1, LD0, 8'hD0, 24'h000002, 0);
    cyc(0, 1, CCU, 8'h00, 24'h000002, 0);
    cyc(0, 0, NOP, 8'h00, 24'h000002, 0);
    cyc(1, 1, LD0, 8'h77, 24'h000000, 1);
    cyc(0, 1, LD1, 8'hFA, 24'h00FA00, 1);
    cyc(0, 1, 4'h9, 8'h00, 24'h00FA00, 0);
    cyc(1, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 1, LD1, 8'hFA, 24'h00FA00, 1);
    cyc(0, 1, CCU, 8'h00, 24'h00FA01, 1);
    cyc(0, 0, NOP, 8'h00, 24'h00FA02, 1);
    cyc(1, 1, LD0, 8'h11, 24'h000000, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 1, CCD, 8'h00, 24'hFFFFFF, 1);
    cyc(1, 0, NOP, 8'h00, 24'h000000, 1);
    cyc(0, 0, NOP, 8'h00, 24'h000000, 1);
    @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL: %0d expectations never compared", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
